// File: rtl/booth_result_collector.sv
// Collects the two-beat serialised Booth product, assembles {hi,lo} and queues it
// in a small FIFO offered over valid/ready; flags sequencing and overflow errors.
module booth_result_collector #(
   parameter int N     = 8,
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           done,
   input  logic           selL,
   input  logic           selR,
   input  logic [N-1:0]   dataIn,
   output logic           canStart,
   output logic           pValid,
   input  logic           pReady,
   output logic [2*N-1:0] product,
   output logic           pFits,
   output logic           errSeq,
   output logic           errOvf,
   input  logic           clrErr
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {
      WAIT_HI,
      WAIT_LO
   } state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     hi_q, hi_d;
   logic [2*N-1:0]   data_q [DEPTH];
   logic             fits_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             err_seq_q, err_seq_d;
   logic             err_ovf_q, err_ovf_d;

   logic             seq_err;
   logic             push_req;
   logic             push;
   logic             pop;
   logic             not_full;
   logic [2*N-1:0]   push_data;
   logic             push_fits;

   // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      seq_err  = 1'b0;
      push_req = 1'b0;
      unique case (state_q)
         WAIT_HI: begin
            if (done) begin
               if (selL && !selR) begin
                  hi_d    = dataIn;
                  state_d = WAIT_LO;
               end else begin
                  seq_err = 1'b1;
               end
            end
         end
         WAIT_LO: begin
            if (done && selR && !selL) begin
               push_req = 1'b1;
               state_d  = WAIT_HI;
            end else if (done && selL && !selR) begin
               seq_err = 1'b1;
               hi_d    = dataIn;
            end else begin
               // The low half must follow the high half on the very next cycle.
               seq_err = 1'b1;
               hi_d    = '0;
               state_d = WAIT_HI;
            end
         end
         default: state_d = WAIT_HI;
      endcase
   end

   assign push_data = {hi_q, dataIn};
   assign push_fits = (hi_q == {N{dataIn[N-1]}});

   assign not_full  = (count_q < CW'(DEPTH));
   assign pop       = pValid && pReady;
   assign push      = push_req && (not_full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   // A new error in the same cycle as clrErr keeps the flag set.
   always_comb begin
      err_seq_d = clrErr ? 1'b0 : err_seq_q;
      err_ovf_d = clrErr ? 1'b0 : err_ovf_q;
      if (seq_err)           err_seq_d = 1'b1;
      if (push_req && !push) err_ovf_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= WAIT_HI;
         hi_q      <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_seq_q <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_seq_q <= err_seq_d;
         err_ovf_q <= err_ovf_d;
      end
   end

   // NOTE: the storage is reset on purpose so product/pFits read 0 out of reset; it is only DEPTH words.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            fits_q[i] <= 1'b0;
         end
      end else if (push) begin
         data_q[wr_ptr_q] <= push_data;
         fits_q[wr_ptr_q] <= push_fits;
      end
   end

   assign pValid   = (count_q != '0);
   assign product  = data_q[rd_ptr_q];
   assign pFits    = fits_q[rd_ptr_q];
   assign canStart = (state_q == WAIT_HI) && not_full;
   assign errSeq   = err_seq_q;
   assign errOvf   = err_ovf_q;

endmodule

// File: tb/tb_booth_result_collector.sv
// Directed bench for booth_result_collector (N=8, DEPTH=2): inputs driven on the
// falling edge, outputs checked on the following falling edge.
module tb_booth_result_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        done, selL, selR, pReady, clrErr;
   logic [7:0]  dataIn;
   logic        canStart, pValid, pFits, errSeq, errOvf;
   logic [15:0] product;

   int total = 0;
   int bad   = 0;

   booth_result_collector #(.N(8), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .done(done), .selL(selL), .selR(selR), .dataIn(dataIn),
      .canStart(canStart), .pValid(pValid), .pReady(pReady), .product(product),
      .pFits(pFits), .errSeq(errSeq), .errOvf(errOvf), .clrErr(clrErr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic idle();
      done = 1'b0; selL = 1'b0; selR = 1'b0; dataIn = 8'h00;
   endtask

   // selL beat, selR beat, then idle; returns at the negedge after the selR edge.
   task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo);
      @(negedge clk); done = 1'b1; selL = 1'b1; selR = 1'b0; dataIn = hi;
      @(negedge clk); selL = 1'b0; selR = 1'b1; dataIn = lo;
      @(negedge clk); idle();
   endtask

   task automatic expect_head(input string name, input logic v, input logic [15:0] p, input logic f);
      total++;
      if (pValid !== v) begin bad++; $display("FAIL %s_valid: got %b want %b", name, pValid, v); end
      if (v) begin
         total++;
         if (product !== p) begin bad++; $display("FAIL %s_product: got %h want %h", name, product, p); end
         total++;
         if (pFits !== f) begin bad++; $display("FAIL %s_fits: got %b want %b", name, pFits, f); end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; pReady = 1'b0; clrErr = 1'b0; idle();
      #12;
      total++;
      if ({pValid, product, pFits, errSeq, errOvf, canStart} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset: got v=%b p=%h f=%b es=%b eo=%b cs=%b want v=0 p=0000 f=0 es=0 eo=0 cs=1",
                  pValid, product, pFits, errSeq, errOvf, canStart);
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_basic();
      pReady = 1'b1;
      send_pair(8'hFF, 8'hF4);
      expect_head("t1", 1'b1, 16'hFFF4, 1'b1);
      @(negedge clk);
      expect_head("t1_popped", 1'b0, 16'h0000, 1'b0);
      pReady = 1'b0;
      send_pair(8'h01, 8'h2C);
      expect_head("t2", 1'b1, 16'h012C, 1'b0);
      pReady = 1'b1;
      @(negedge clk); pReady = 1'b0;
      expect_head("t2_popped", 1'b0, 16'h0000, 1'b0);
      total++;
      if (errSeq !== 1'b0 || errOvf !== 1'b0) begin
         bad++; $display("FAIL t12_errs: got es=%b eo=%b want 0 0", errSeq, errOvf);
      end
   endtask

   task automatic test_overflow();
      pReady = 1'b0;
      send_pair(8'h11, 8'h22);
      total++;
      if (canStart !== 1'b1) begin bad++; $display("FAIL t3_cs1: got %b want 1", canStart); end
      send_pair(8'h33, 8'h44);
      total++;
      if (canStart !== 1'b0) begin bad++; $display("FAIL t3_cs2: got %b want 0", canStart); end
      total++;
      if (errOvf !== 1'b0) begin bad++; $display("FAIL t3_ovf_early: got %b want 0", errOvf); end
      send_pair(8'h55, 8'h66);
      total++;
      if (errOvf !== 1'b1) begin bad++; $display("FAIL t3_ovf: got %b want 1", errOvf); end
      expect_head("t3_head0", 1'b1, 16'h1122, 1'b0);
      pReady = 1'b1;
      @(negedge clk);
      expect_head("t3_head1", 1'b1, 16'h3344, 1'b0);
      @(negedge clk); pReady = 1'b0;
      expect_head("t3_empty", 1'b0, 16'h0000, 1'b0);
      clrErr = 1'b1;
      @(negedge clk); clrErr = 1'b0;
      total++;
      if (errOvf !== 1'b0) begin bad++; $display("FAIL t3_clr: got %b want 0", errOvf); end
   endtask

   task automatic test_full_pop();
      pReady = 1'b0;
      send_pair(8'h00, 8'h7F);
      send_pair(8'hFF, 8'h80);
      @(negedge clk); done = 1'b1; selL = 1'b1; dataIn = 8'h80;
      @(negedge clk); selL = 1'b0; selR = 1'b1; dataIn = 8'h00; pReady = 1'b1;
      @(negedge clk); idle(); pReady = 1'b0;
      total++;
      if (errOvf !== 1'b0) begin bad++; $display("FAIL t4_ovf: got %b want 0", errOvf); end
      total++;
      if (canStart !== 1'b0) begin bad++; $display("FAIL t4_still_full: got %b want 0", canStart); end
      expect_head("t4_head1", 1'b1, 16'hFF80, 1'b1);
      pReady = 1'b1;
      @(negedge clk);
      expect_head("t4_head2", 1'b1, 16'h8000, 1'b0);
      @(negedge clk); pReady = 1'b0;
      expect_head("t4_empty", 1'b0, 16'h0000, 1'b0);
   endtask

   task automatic test_seq_err();
      @(negedge clk); done = 1'b1; selR = 1'b1; dataIn = 8'h12;
      @(negedge clk); idle();
      total++;
      if (errSeq !== 1'b1) begin bad++; $display("FAIL t5_selr_first: got %b want 1", errSeq); end
      expect_head("t5_nopush", 1'b0, 16'h0000, 1'b0);
      clrErr = 1'b1;
      @(negedge clk); clrErr = 1'b0;
      total++;
      if (errSeq !== 1'b0) begin bad++; $display("FAIL t5_clr: got %b want 0", errSeq); end
      done = 1'b1; selL = 1'b1; dataIn = 8'hAB;
      @(negedge clk); idle();
      total++;
      if (canStart !== 1'b0) begin bad++; $display("FAIL t5_wait_lo: got %b want 0", canStart); end
      @(negedge clk);
      total++;
      if (errSeq !== 1'b1 || canStart !== 1'b1) begin
         bad++; $display("FAIL t5_abandon: got es=%b cs=%b want 1 1", errSeq, canStart);
      end
      clrErr = 1'b1; done = 1'b1; selR = 1'b1;
      @(negedge clk); idle(); clrErr = 1'b0;
      total++;
      if (errSeq !== 1'b1) begin bad++; $display("FAIL t5_err_wins: got %b want 1", errSeq); end
      clrErr = 1'b1;
      @(negedge clk); clrErr = 1'b0;
      // Double selL relatches the high half; the pair still completes.
      done = 1'b1; selL = 1'b1; dataIn = 8'h10;
      @(negedge clk); dataIn = 8'h20;
      @(negedge clk); selL = 1'b0; selR = 1'b1; dataIn = 8'h30;
      @(negedge clk); idle();
      total++;
      if (errSeq !== 1'b1) begin bad++; $display("FAIL t5_relatch_err: got %b want 1", errSeq); end
      expect_head("t5_relatch", 1'b1, 16'h2030, 1'b0);
      pReady = 1'b1; clrErr = 1'b1;
      @(negedge clk); pReady = 1'b0; clrErr = 1'b0;
   endtask

   task automatic test_reset_mid();
      pReady = 1'b0;
      send_pair(8'h12, 8'h34);
      @(negedge clk); done = 1'b1; selL = 1'b1; dataIn = 8'h77;
      @(negedge clk); idle(); rst = 1'b0;
      #1;
      total++;
      if ({pValid, canStart, product, errSeq} !== {1'b0, 1'b1, 16'h0000, 1'b0}) begin
         bad++;
         $display("FAIL t6_reset: got v=%b cs=%b p=%h es=%b want v=0 cs=1 p=0000 es=0",
                  pValid, canStart, product, errSeq);
      end
      @(negedge clk); rst = 1'b1;
      send_pair(8'hFE, 8'h85);
      expect_head("t6_after", 1'b1, 16'hFE85, 1'b0);
      total++;
      if (errSeq !== 1'b0) begin bad++; $display("FAIL t6_noerr: got %b want 0", errSeq); end
      pReady = 1'b1;
      @(negedge clk); pReady = 1'b0;
      expect_head("t6_empty", 1'b0, 16'h0000, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop();
      test_seq_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
